// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes the PS/2 clock and data lines, deframes 11-bit scancode frames
// with odd parity, and buffers good bytes in a small FIFO with a sticky overflow flag.
module ps2_scancode_rx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_req,
  input  logic       clr_status,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s2_q, clk_hist_q;
  logic          data_s1_q, data_s2_q;
  logic          fall_tick;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_err_q, frame_err_d;
  logic          push;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          empty, full, pop, wr_en, ovf_set;

  // Synchronizers idle high so reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_hist_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_hist_q <= clk_s2_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall_tick = clk_hist_q & ~clk_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    parity_d    = parity_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    if (state_q == S_IDLE || fall_tick) tmo_d = '0;
    else                                tmo_d = tmo_q + TW'(1);

    if (state_q != S_IDLE && !fall_tick && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = S_IDLE;
      shift_d     = '0;
      bit_cnt_d   = '0;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end else if (fall_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!data_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        S_DATA: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = data_s2_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (data_s2_q && (^{shift_q, parity_q})) push = 1'b1;
          else                                     frame_err_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = rd_req & ~empty;
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - (AW+1)'(1);
    if (ovf_set)         overflow_d = 1'b1;
    else if (clr_status) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rd_valid  = ~empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames push expected bytes into a queue,
// and a negedge monitor pops and compares whenever a read is granted.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

  localparam int H   = 20;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_req = 1'b0;
  logic       clr_status = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, overflow;

  int errors = 0;
  int checks = 0;
  int fe_count = 0;
  int fe_base;
  bit fe_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  ps2_scancode_rx #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_req(rd_req), .clr_status(clr_status), .rd_data(rd_data),
    .rd_valid(rd_valid), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
    $fatal(1);
  end

  always @(negedge clk) begin
    if (reset) begin
      fe_prev = 1'b0;
    end else begin
      if (frame_err) begin
        fe_count++;
        checks++;
        if (fe_prev) begin
          errors++;
          $display("FAIL frame_err_width: got 2+ cycles high, expected 1");
        end
      end
      fe_prev = frame_err;
      if (rd_req && rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %02h, expected no data", rd_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (rd_data !== exp_b) begin
            errors++;
            $display("FAIL pop_data: got %02h, expected %02h", rd_data, exp_b);
          end
        end
      end else if (rd_req && exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL pop_missing: got rd_valid=0, expected %02h", exp_q[0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                           input int first, input int last, input bit pop_stop);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    for (int i = first; i <= last; i++) begin
      ps2_data = fr[i];
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (pop_stop && i == 10) begin
        @(posedge clk);
        @(posedge clk);
        #1 rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        repeat (H - 3) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic good(input logic [7:0] b, input bit expect_stored);
    if (expect_stored) exp_q.push_back(b);
    send_bits(b, 1'b0, 1'b0, 0, 10, 1'b0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    @(posedge clk);
    #1 rd_req = 1'b1;
    @(posedge clk);
    #1 rd_req = 1'b0;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overflow", overflow, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // single good frame then pop
    good(8'h1C, 1'b1);
    chk("1c_rd_valid", rd_valid, 1);
    chk("1c_rd_data", rd_data, 8'h1C);
    do_pop();
    #1;
    chk("1c_after_pop_valid", rd_valid, 0);
    chk("1c_after_pop_data", rd_data, 0);
    chk("1c_no_frame_err", fe_count, 0);

    // bad parity, then bad stop
    send_bits(8'h1C, 1'b1, 1'b0, 0, 10, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("badpar_frame_err", fe_count, 1);
    chk("badpar_rd_valid", rd_valid, 0);
    send_bits(8'h1C, 1'b0, 1'b1, 0, 10, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("badstop_frame_err", fe_count, 2);
    chk("badstop_rd_valid", rd_valid, 0);

    // overflow: fifth frame dropped
    good(8'h1C, 1'b1);
    good(8'hF0, 1'b1);
    good(8'h1C, 1'b1);
    good(8'h32, 1'b1);
    chk("full_no_overflow", overflow, 0);
    good(8'h21, 1'b0);
    chk("overflow_set", overflow, 1);
    repeat (4) do_pop();
    #1;
    chk("drained_rd_valid", rd_valid, 0);
    do_pop();
    #1;
    chk("empty_pop_rd_data", rd_data, 0);
    chk("overflow_sticky", overflow, 1);
    @(posedge clk);
    #1 clr_status = 1'b1;
    @(posedge clk);
    #1 clr_status = 1'b0;
    chk("overflow_cleared", overflow, 0);

    // mid-frame timeout
    fe_base = fe_count;
    send_bits(8'h45, 1'b0, 1'b0, 0, 3, 1'b0);
    repeat (TMO + 20) @(posedge clk);
    #1;
    chk("timeout_frame_err", fe_count - fe_base, 1);
    chk("timeout_rd_valid", rd_valid, 0);
    good(8'h45, 1'b1);
    chk("after_timeout_data", rd_data, 8'h45);
    do_pop();

    // full FIFO with push and pop in the same cycle
    good(8'h11, 1'b1);
    good(8'h22, 1'b1);
    good(8'h33, 1'b1);
    good(8'h44, 1'b1);
    exp_q.push_back(8'h29);
    send_bits(8'h29, 1'b0, 1'b0, 0, 10, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("pushpop_no_overflow", overflow, 0);
    repeat (4) do_pop();
    #1;
    chk("pushpop_drained", rd_valid, 0);

    // reset mid-frame discards partial byte and stored data
    good(8'h77, 1'b1);
    send_bits(8'hE1, 1'b0, 1'b0, 0, 5, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_rd_valid", rd_valid, 0);
    chk("midreset_rd_data", rd_data, 0);
    chk("midreset_frame_err", frame_err, 0);
    reset = 1'b0;
    fe_base = fe_count;
    send_bits(8'hE1, 1'b0, 1'b0, 6, 10, 1'b0);
    repeat (TMO + 20) @(posedge clk);
    #1;
    chk("tail_no_frame_err", fe_count - fe_base, 0);
    chk("tail_no_byte", rd_valid, 0);
    good(8'h5A, 1'b1);
    chk("after_reset_data", rd_data, 8'h5A);
    do_pop();
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered scancodes (power of 2, ≥2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, idle clk cycles mid-frame before abort (1 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  keyboard clock, asynchronous, idle high.
REQ-006 SHALL have port ps2_data  input  1  keyboard data, asynchronous, idle high.
REQ-007 SHALL have port rd_req  input  1  pop head scancode this cycle.
REQ-008 SHALL have port clr_status  input  1  clear sticky overflow flag.
REQ-009 SHALL have port rd_data  output  8  FIFO head scancode; 0x00 when empty.
REQ-010 SHALL have port rd_valid  output  1  FIFO not empty; also the core interrupt request.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on rejected frame.
REQ-012 SHALL have port overflow  output  1  sticky: a good frame was dropped because FIFO was full.

Function
REQ-013 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer, plus one history flop on synced ps2_clk.
REQ-014 SHALL generate fall_tick when history=1 and synced ps2_clk=0; sample synced ps2_data in that cycle.
REQ-015 SHALL implement FSM IDLE, DATA, PARITY, STOP; only fall_tick advances it.
REQ-016 IDLE: fall_tick with data=0 (start) -> DATA, bit count 0; data=1 ignored, stay IDLE.
REQ-017 DATA: shift sampled bit in LSB first; after 8th bit -> PARITY.
REQ-018 PARITY: store bit -> STOP.
REQ-019 STOP: go IDLE; frame good when stop=1 and total ones across 8 data bits plus parity is odd.
REQ-020 Good frame SHALL be written to FIFO on the clk edge ending the STOP fall_tick cycle; rd_valid high from next cycle.
REQ-021 Bad parity or stop=0 SHALL pulse frame_err for exactly 1 cycle; nothing written.
REQ-022 A counter SHALL reset on every fall_tick and increment in non-IDLE states. At TIMEOUT_CYCLES it SHALL force IDLE, pulse frame_err, discard partial byte.
REQ-023 rd_req with FIFO empty SHALL be ignored, with no state change.
REQ-024 Good frame with FIFO full and no rd_req SHALL be dropped, set overflow, leave FIFO contents unchanged.
REQ-025 Good frame with FIFO full and rd_req in the same cycle SHALL pop head and push new byte; no overflow.
REQ-026 Push and pop in the same cycle on a non-empty FIFO SHALL keep count unchanged.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.
REQ-028 overflow SHALL stay set until clr_status or reset. A new overflow in the same cycle as clr_status leaves it set.
REQ-029 rd_data SHALL be combinational from FIFO head and forced 0x00 when empty.

Reset
REQ-030 While reset=1 the block SHALL hold: FSM=IDLE, shift/bit/timeout counters=0, FIFO pointers and count=0, rd_valid=0, rd_data=0x00, frame_err=0, overflow=0. Synchronizer flops SHALL be set to 1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame. Bits of that frame after reset release (stop=1 without start) SHALL not produce a byte or frame_err.

Verification
REQ-032 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,p=0,stop=1; 30 µs half-period) -> rd_valid=1, rd_data=0x1C, frame_err never high. rd_req one cycle -> rd_valid=0, rd_data=0x00.
REQ-033 Frame 0x1C with parity=1 -> single-cycle frame_err, rd_valid stays 0.
REQ-034 Five frames 0x1C,0xF0,0x1C,0x32,0x21 with no rd_req -> overflow=1; pops return 0x1C,0xF0,0x1C,0x32 then rd_valid=0. clr_status -> overflow=0.
REQ-035 Start bit plus 3 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE. Following full frame 0x45 -> rd_data=0x45.
REQ-036 FIFO full (4 entries) with frame 0x29 completing in the same cycle as rd_req -> overflow=0, count stays 4, last pop returns 0x29.
REQ-037 Reset pulse after the 5th data bit of a frame -> all outputs at reset values. Remaining edges produce no byte; next complete frame 0x5A is received correctly.
